vliw_regfile_2w: RTL and testbench
==================================

// Module: vliw_regfile_2w
// PURPOSE
//  Parametrised general-purpose register file for the VLIW datapath: DEPTH entries of WIDTH bits,
//  two write ports (one per issue slot) and NUM_RD asynchronous read ports.
//  Detects same-address write collisions between the two slots and records them for debug.
//  Sits between decode (read addresses) and writeback (both slots' results).
// PARAMETERS
//  WIDTH      32  data width of each entry
//  DEPTH      8   number of entries (power of two, >=2)
//  NUM_RD     4   number of read ports
//  ZERO_REG   1   1: entry 0 reads as 0 and ignores writes; 0: entry 0 is an ordinary register
// PORTS
//  clk        in   1                 clock; all state updates on negedge clk
//  reset      in   1                 synchronous, active-high reset, sampled on negedge clk
//  we0        in   1                 slot-0 write enable
//  waddr0     in   AW=$clog2(DEPTH)  slot-0 write address
//  wdata0     in   WIDTH             slot-0 write data
//  we1        in   1                 slot-1 write enable
//  waddr1     in   AW                slot-1 write address
//  wdata1     in   WIDTH             slot-1 write data
//  raddr      in   NUM_RD*AW         packed read addresses, port i at [i*AW +: AW]
//  rdata      out  NUM_RD*WIDTH      packed read data, port i at [i*WIDTH +: WIDTH]
//  clr_coll   in   1                 clears coll_flag and coll_cnt
//  coll_flag  out  1                 sticky: a write collision has occurred
//  coll_cnt   out  8                 saturating count of write collisions
// BEHAVIOUR
//  - Reset: all entries <= 0, coll_flag <= 0, coll_cnt <= 0; rdata therefore reads 0 after reset.
//    Reset overrides every write and clr_coll in the same edge.
//  - Write: on negedge clk, entry[waddrN] <= wdataN when weN=1. Distinct addresses: both commit.
//  - Collision: we0 & we1 & waddr0==waddr1 -> slot 1 wins (later slot in program order);
//    coll_flag <= 1; coll_cnt <= coll_cnt+1, saturating at 8'hFF.
//    With ZERO_REG=1 and waddr0==waddr1==0 it is NOT a collision (both writes are discarded).
//  - clr_coll and a collision on the same edge: clear wins, then the new collision counts:
//    coll_flag <= 1, coll_cnt <= 1.
//  - Read: purely combinational, rdata[i] = entry[raddr[i]]; zero latency, no enable.
//    Without bypass a read of an address being written returns the old value until the negedge.
//  - ZERO_REG=1: rdata for address 0 is 0 regardless of stored state; writes to 0 are dropped.
//  - Out-of-range addresses cannot occur (DEPTH is a power of two).
// CONFIGURATION
//  - Macro REGFILE_BYPASS_EN.
//    Defined: read port i returns write data whenever weN=1 and waddrN==raddr[i] in the same cycle,
//    slot 1 taking priority over slot 0; ZERO_REG masking still applies after bypass.
//    Not defined: no forwarding; rdata always reflects stored entries only.
//  - Collision logic and storage are identical in both builds.
// STRUCTURE
//  - Shared package regfile_pkg: RF_WIDTH=32, RF_DEPTH=8, RF_AW=$clog2(RF_DEPTH), RF_NUM_RD=4,
//    COLL_CNT_W=8, typedef logic [RF_WIDTH-1:0] rf_word_t, typedef logic [RF_AW-1:0] rf_addr_t.
//  - Sub-module regfile_entry_2w: one WIDTH register with two write sources, per-source enable,
//    slot-1 priority mux and synchronous reset; instantiated DEPTH times (entry 0 skipped if ZERO_REG).
//  - Top level: per-entry write decode, collision detector and counter, NUM_RD read muxes, optional bypass.
// TESTING
//  1 Reset: write all entries, assert reset one negedge -> every rdata port reads 0, coll_flag=0, coll_cnt=0.
//  2 Dual write: we0 addr3=32'hAAAA_0001, we1 addr5=32'h5555_0002 -> next cycle raddr 3/5 read those values.
//  3 Collision: we0,we1 both addr2, wdata0=32'h1111_1111, wdata1=32'h2222_2222 -> entry2=32'h2222_2222,
//    coll_flag=1, coll_cnt=1; repeat 300 times -> coll_cnt=8'hFF (no wrap); clr_coll -> both 0.
//  4 Zero reg (ZERO_REG=1): we0 addr0=32'hDEAD_BEEF and we1 addr0 -> raddr 0 reads 0, coll_cnt unchanged.
//  5 Bypass: we1 addr4=32'hCAFE_F00D, raddr[0]=4 same cycle -> REGFILE_BYPASS_EN: CAFE_F00D before negedge;
//    without macro: old value before negedge, CAFE_F00D after.
//  6 Reset mid-write: reset=1 with we0 addr6=32'h1234_5678 and a collision -> entry6=0, coll_cnt=0.

Source files
------------

// File: rtl/vliw_regfile_2w_pkg.sv
// Shared constants and types for the dual-write VLIW register file.
package regfile_pkg;

  localparam int unsigned RF_WIDTH   = 32;
  localparam int unsigned RF_DEPTH   = 8;
  localparam int unsigned RF_AW      = $clog2(RF_DEPTH);
  localparam int unsigned RF_NUM_RD  = 4;
  localparam int unsigned COLL_CNT_W = 8;

  typedef logic [RF_WIDTH-1:0] rf_word_t;
  typedef logic [RF_AW-1:0]    rf_addr_t;

  // Saturating increment for the collision counter.
  function automatic logic [COLL_CNT_W-1:0] sat_inc(input logic [COLL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vliw_regfile_2w_if.sv
// Write, read and collision-debug signals of the dual-write register file.
interface vliw_regfile_2w_if #(
  parameter int unsigned WIDTH  = regfile_pkg::RF_WIDTH,
  parameter int unsigned DEPTH  = regfile_pkg::RF_DEPTH,
  parameter int unsigned NUM_RD = regfile_pkg::RF_NUM_RD
);
  import regfile_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic                    we0;
  logic [AW-1:0]           waddr0;
  logic [WIDTH-1:0]        wdata0;
  logic                    we1;
  logic [AW-1:0]           waddr1;
  logic [WIDTH-1:0]        wdata1;
  logic [NUM_RD*AW-1:0]    raddr;
  logic [NUM_RD*WIDTH-1:0] rdata;
  logic                    clr_coll;
  logic                    coll_flag;
  logic [COLL_CNT_W-1:0]   coll_cnt;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, clr_coll,
    input  rdata, coll_flag, coll_cnt
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, clr_coll,
    output rdata, coll_flag, coll_cnt
  );

endinterface

// File: rtl/vliw_regfile_2w_entry.sv
// One register-file entry with two write sources; slot 1 wins when both are enabled.
module regfile_entry_2w #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             we0_i,
  input  logic [Width-1:0] wdata0_i,
  input  logic             we1_i,
  input  logic [Width-1:0] wdata1_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (we1_i) begin
      data_d = wdata1_i;
    end else if (we0_i) begin
      data_d = wdata0_i;
    end
  end

  always_ff @(negedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/vliw_regfile_2w.sv
// Dual-write, multi-read register file with write-collision debug counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module vliw_regfile_2w
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned NUM_RD   = RF_NUM_RD,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               reset,
  vliw_regfile_2w_if.slave   rf
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] ent [DEPTH];

  logic zero_hit;
  logic coll;

  // Both slots writing entry 0 of a hardwired-zero file is a no-op, not a collision.
  always_comb begin
    zero_hit = (ZERO_REG != 0) && (rf.waddr0 == '0);
    coll     = rf.we0 && rf.we1 && (rf.waddr0 == rf.waddr1) && !zero_hit;
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    if ((ZERO_REG != 0) && (e == 0)) begin : g_zero
      assign ent[e] = '0;
    end else begin : g_reg
      logic wen0, wen1;
      assign wen0 = rf.we0 && (rf.waddr0 == AW'(e));
      assign wen1 = rf.we1 && (rf.waddr1 == AW'(e));

      regfile_entry_2w #(
        .Width (WIDTH)
      ) u_entry (
        .clk_i    (clk),
        .reset_i  (reset),
        .we0_i    (wen0),
        .wdata0_i (rf.wdata0),
        .we1_i    (wen1),
        .wdata1_i (rf.wdata1),
        .q_o      (ent[e])
      );
    end
  end

  logic                  coll_flag_d, coll_flag_q;
  logic [COLL_CNT_W-1:0] coll_cnt_d, coll_cnt_q;

  // A clear on the same edge as a collision restarts the count at one.
  always_comb begin
    coll_flag_d = coll_flag_q;
    coll_cnt_d  = coll_cnt_q;
    if (rf.clr_coll) begin
      coll_flag_d = coll;
      coll_cnt_d  = coll ? COLL_CNT_W'(1) : '0;
    end else if (coll) begin
      coll_flag_d = 1'b1;
      coll_cnt_d  = sat_inc(coll_cnt_q);
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      coll_flag_q <= 1'b0;
      coll_cnt_q  <= '0;
    end else begin
      coll_flag_q <= coll_flag_d;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

  assign rf.coll_flag = coll_flag_q;
  assign rf.coll_cnt  = coll_cnt_q;

  logic [AW-1:0]           rd_addr [NUM_RD];
  logic [WIDTH-1:0]        rd_val  [NUM_RD];
  logic [NUM_RD*WIDTH-1:0] rdata;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr[i] = rf.raddr[i*AW +: AW];
      rd_val[i]  = ent[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
      if (rf.we1 && (rf.waddr1 == rd_addr[i])) begin
        rd_val[i] = rf.wdata1;
      end else if (rf.we0 && (rf.waddr0 == rd_addr[i])) begin
        rd_val[i] = rf.wdata0;
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr[i] == '0)) begin
        rd_val[i] = '0;
      end
      rdata[i*WIDTH +: WIDTH] = rd_val[i];
    end
  end

  assign rf.rdata = rdata;

endmodule

// File: tb/tb_vliw_regfile_2w.sv
// Self-checking bench for vliw_regfile_2w (default parameters, ZERO_REG=1).
module tb_vliw_regfile_2w;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vliw_regfile_2w_if bus ();

  vliw_regfile_2w dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [8];
  logic        mflag;
  logic [7:0]  mcnt;

  typedef struct {
    string       name;
    logic        we0;
    logic [2:0]  a0;
    logic [31:0] d0;
    logic        we1;
    logic [2:0]  a1;
    logic [31:0] d1;
    logic        clr;
    logic [2:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_flag;
    logic [7:0]  exp_cnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        flag;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int p);
    return bus.rdata[p*32 +: 32];
  endfunction

  task automatic drive(input logic we0, input logic [2:0] a0, input logic [31:0] d0,
                       input logic we1, input logic [2:0] a1, input logic [31:0] d1,
                       input logic clr);
    bus.we0 = we0; bus.waddr0 = a0; bus.wdata0 = d0;
    bus.we1 = we1; bus.waddr1 = a1; bus.wdata1 = d1;
    bus.clr_coll = clr;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
  endtask

  task automatic set_raddr(input int base);
    for (int i = 0; i < 4; i++) bus.raddr[i*3 +: 3] = 3'(base + i);
  endtask

  // Update the reference model from the driven inputs, then let the negedge commit.
  task automatic step();
    logic coll;
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
      mflag = 1'b0;
      mcnt  = '0;
    end else begin
      coll = bus.we0 && bus.we1 && (bus.waddr0 == bus.waddr1) && (bus.waddr0 != 0);
      if (bus.we0 && bus.waddr0 != 0) mem[bus.waddr0] = bus.wdata0;
      if (bus.we1 && bus.waddr1 != 0) mem[bus.waddr1] = bus.wdata1;
      if (bus.clr_coll) begin
        mflag = coll;
        mcnt  = coll ? 8'd1 : 8'd0;
      end else if (coll) begin
        mflag = 1'b1;
        if (mcnt != 8'hFF) mcnt = mcnt + 8'd1;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int base = 0; base < 8; base += 4) begin
      set_raddr(base);
      #1;
      for (int i = 0; i < 4; i++) chk(tag, rd(i), mem[base+i]);
    end
    chk({tag, "_flag"}, 32'(bus.coll_flag), 32'(mflag));
    chk({tag, "_cnt"}, 32'(bus.coll_cnt), 32'(mcnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    exp_t e;
    idle();
    set_raddr(0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all("post_reset");

    // Fill every entry, then reset for a single edge.
    for (int k = 0; k < 8; k += 2) begin
      drive(1'b1, 3'(k), 32'h100 + k, 1'b1, 3'(k + 1), 32'h200 + k + 1, 1'b0);
      step();
    end
    check_all("fill");
    chk("fill_e5", rd(1), 32'h0000_0205);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    check_all("reset_clears");
    chk("reset_e1", rd(1), 32'h0);

    vecs[0] = '{"dual_a3", 1'b1, 3'd3, 32'hAAAA_0001, 1'b1, 3'd5, 32'h5555_0002, 1'b0,
                3'd3, 32'hAAAA_0001, 1'b0, 8'd0};
    vecs[1] = '{"dual_a5", 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0,
                3'd5, 32'h5555_0002, 1'b0, 8'd0};
    vecs[2] = '{"coll_a2", 1'b1, 3'd2, 32'h1111_1111, 1'b1, 3'd2, 32'h2222_2222, 1'b0,
                3'd2, 32'h2222_2222, 1'b1, 8'd1};
    vecs[3] = '{"zero_a0", 1'b1, 3'd0, 32'hDEAD_BEEF, 1'b1, 3'd0, 32'h0000_0BAD, 1'b0,
                3'd0, 32'h0, 1'b1, 8'd1};
    vecs[4] = '{"wr_a7", 1'b1, 3'd7, 32'h7777_7777, 1'b0, 3'd0, 32'h0, 1'b0,
                3'd7, 32'h7777_7777, 1'b1, 8'd1};
    vecs[5] = '{"clr_coll", 1'b1, 3'd1, 32'h0101_0101, 1'b1, 3'd1, 32'h0202_0202, 1'b1,
                3'd1, 32'h0202_0202, 1'b1, 8'd1};
    vecs[6] = '{"coll_a6", 1'b1, 3'd6, 32'h6060_6060, 1'b1, 3'd6, 32'h6161_6161, 1'b0,
                3'd6, 32'h6161_6161, 1'b1, 8'd2};
    vecs[7] = '{"clr_only", 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1,
                3'd2, 32'h2222_2222, 1'b0, 8'd0};
    vecs[8] = '{"over_a3", 1'b1, 3'd4, 32'h4444_4444, 1'b1, 3'd3, 32'h3333_3333, 1'b0,
                3'd3, 32'h3333_3333, 1'b0, 8'd0};

    foreach (vecs[k]) begin
      drive(vecs[k].we0, vecs[k].a0, vecs[k].d0, vecs[k].we1, vecs[k].a1, vecs[k].d1,
            vecs[k].clr);
      set_raddr(int'(vecs[k].ra));
      sb.push_back('{vecs[k].name, vecs[k].exp_rd, vecs[k].exp_flag, vecs[k].exp_cnt});
      step();
      e = sb.pop_front();
      chk({e.name, "_rd"}, rd(0), e.rd);
      chk({e.name, "_flag"}, 32'(bus.coll_flag), 32'(e.flag));
      chk({e.name, "_cnt"}, 32'(bus.coll_cnt), 32'(e.cnt));
    end
    idle();
    check_all("after_table");

    // Counter saturation over 300 collisions, then clear.
    drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
    step();
    set_raddr(2);
    for (int n = 0; n < 300; n++) begin
      drive(1'b1, 3'd2, 32'h1111_1111, 1'b1, 3'd2, 32'h2222_2222, 1'b0);
      step();
      if (n == 0) begin
        chk("coll_first_cnt", 32'(bus.coll_cnt), 32'd1);
        chk("coll_first_rd", rd(0), 32'h2222_2222);
      end
      if (n == 254) chk("coll_255", 32'(bus.coll_cnt), 32'hFF);
    end
    chk("coll_sat_cnt", 32'(bus.coll_cnt), 32'hFF);
    chk("coll_sat_flag", 32'(bus.coll_flag), 32'd1);
    drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
    step();
    chk("clr_cnt", 32'(bus.coll_cnt), 32'd0);
    chk("clr_flag", 32'(bus.coll_flag), 32'd0);

    // Same-cycle read of an entry being written.
    idle();
    set_raddr(4);
    drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd4, 32'hCAFE_F00D, 1'b0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_pre", rd(0), 32'hCAFE_F00D);
`else
    chk("nobypass_pre", rd(0), mem[4]);
`endif
    step();
    chk("bypass_post", rd(0), 32'hCAFE_F00D);

    // Writes to entry 0 stay invisible even while they are in flight.
    set_raddr(0);
    drive(1'b1, 3'd0, 32'hDEAD_BEEF, 1'b1, 3'd0, 32'hFEED_FACE, 1'b0);
    #1;
    chk("zero_pre", rd(0), 32'h0);
    step();
    chk("zero_post", rd(0), 32'h0);
    chk("zero_cnt", 32'(bus.coll_cnt), 32'd0);

    // Reset beats a write and a collision on the same edge.
    drive(1'b1, 3'd6, 32'h6666_6666, 1'b1, 3'd6, 32'h6767_6767, 1'b0);
    step();
    chk("pre_rst_cnt", 32'(bus.coll_cnt), 32'd1);
    reset = 1'b1;
    drive(1'b1, 3'd6, 32'h1234_5678, 1'b1, 3'd6, 32'h8765_4321, 1'b0);
    step();
    reset = 1'b0;
    idle();
    set_raddr(6);
    #1;
    chk("rst_mid_e6", rd(0), 32'h0);
    chk("rst_mid_cnt", 32'(bus.coll_cnt), 32'd0);
    chk("rst_mid_flag", 32'(bus.coll_flag), 32'd0);
    check_all("rst_mid_all");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
